temporizador_bcd: RTL and testbench
===================================

# temporizador_bcd

- BCD countdown timer (HH:MM:SS) that produces the count byte consumed by the timer register stage.
- Holds a user-programmed duration, decrements it once per second while running, and raises `estado_alarma` on reaching 00:00:00.
- The alarm stays latched until dismissed.
- One byte of the live count is presented at a time via `field_sel`; it drives the timer register's count input and the VGA path.

## Interface
- `CLK_HZ`, default 100_000_000, system clock frequency.
- `TICK_HZ`, default 1, decrement rate; `PRESCALE = CLK_HZ/TICK_HZ`, must be ≥ 2.
- `clk  in  1` system clock; all logic on rising edge.
- `reset  in  1` synchronous, active-high reset.
- `load  in  1` one-cycle pulse; capture `in_hora`/`in_min`/`in_seg`.
- `in_hora  in  8` BCD hours, valid 0x00–0x23.
- `in_min  in  8` BCD minutes, valid 0x00–0x59.
- `in_seg  in  8` BCD seconds, valid 0x00–0x59.
- `start  in  1` one-cycle pulse; begin or resume counting.
- `pause  in  1` one-cycle pulse; freeze count.
- `btn_desactivar  in  1` level; dismisses the alarm.
- `field_sel  in  2` byte select: 0 = seg, 1 = min, 2 = hora, 3 = 0x00.
- `out_count_dato  out  8` registered selected BCD byte.
- `estado_alarma  out  1` high while the alarm is latched.
- `running  out  1` high in RUN.
- `load_err  out  1` one-cycle pulse on a rejected load.

## Operation
- States: IDLE, RUN, PAUSE, ALARM.
- **Priority within a cycle:** reset > load > btn_desactivar > pause > start.
- **IDLE:**
  - `load` with valid BCD: count ← inputs; also stored in `prog` register.
  - `load` with invalid data (any nibble > 9, or field above its limit): count unchanged, `load_err` = 1 for one cycle.
  - `start` with count ≠ 0 → RUN, prescaler cleared. `start` with count = 0 is ignored.
- **RUN:**
  - Each tick decrements the count: seconds 00 borrows from minutes (sec → 59); minutes 00 borrows from hours (min → 59).
  - A tick that makes the count 00:00:00 → ALARM on the same edge.
  - `pause` → PAUSE; prescaler value is retained.
  - `load` is ignored in RUN (no `load_err`).
- **PAUSE:**
  - `start` → RUN, prescaler resumes from its retained value.
  - `load` is accepted as in IDLE; the state stays PAUSE.
- **ALARM:**
  - Count held at 0; `estado_alarma` = 1.
  - `btn_desactivar` = 1 → IDLE; `estado_alarma` clears on the next edge.
  - `start`, `pause` and `load` are ignored.
- **Prescaler:** counts 0..PRESCALE-1 only in RUN; tick fires in the cycle where it equals PRESCALE-1, then wraps to 0.
- **BCD rule:** each digit decrements with borrow; a borrow out of hours never occurs, because zero is detected first.

## Timing
- **Reset values:** state IDLE, count and `prog` = 0, prescaler = 0, `out_count_dato` = 0x00, `estado_alarma` = 0, `running` = 0, `load_err` = 0.
- **First decrement:** visible PRESCALE cycles after the `start` edge.
- **`out_count_dato` latency:** 1 cycle after a change of `field_sel` or of the count.
- **`running` / `estado_alarma`:** registered; they change on the same edge as the state.
- **Reset mid-RUN:** all state cleared on the next edge; `prog` is lost.

## Configuration
- **`TIMER_AUTORELOAD_EN` defined:** leaving ALARM via `btn_desactivar` reloads count ← `prog` and enters IDLE, ready for a new `start`.
- **Undefined:** count stays 00:00:00 after dismissal, and a new `load` is required.

## Structure
- **Package `temporizador_pkg`:**
  - state enum;
  - `field_sel` encodings (SEL_SEG, SEL_MIN, SEL_HORA, SEL_NONE);
  - BCD limit constants 0x59 and 0x23.
- **Sub-module `bcd_dec2`:**
  - 2-digit BCD decrement; inputs value, borrow_in, wrap value; outputs next value, borrow_out.
  - Instanced for seconds and minutes; hours use it with wrap unused.

## Test plan
Use CLK_HZ = 4, TICK_HZ = 1, so PRESCALE = 4.
- Load 00:00:03, `start` → count reads 02, 01, 00 at cycles 4, 8, 12 after start; `estado_alarma` = 1 at cycle 12; `running` = 0.
- Load 01:00:00, run one tick → 00:59:59 (borrow chain); `field_sel` = 2, 1, 0 reads 0x00, 0x59, 0x59 with 1-cycle latency.
- Load `in_min` = 0x60 → `load_err` pulse; count unchanged. Load `in_seg` = 0x1A → `load_err` pulse.
- RUN, `pause` at prescaler = 2, hold 10 cycles, then `start` → next decrement 2 cycles later.
- In ALARM, assert `btn_desactivar` together with `start` → IDLE with `start` ignored. With autoreload, count = `prog`; without it, count = 0.
- `start` with count 0 → stays IDLE. `reset` mid-RUN → all outputs at reset values next cycle.

Source files
------------

// File: rtl/temporizador_pkg.sv
// Shared types and constants for the BCD countdown timer.
// The TIMER_AUTORELOAD_EN option is handled in temporizador_bcd.sv.
package temporizador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam logic [1:0] SEL_SEG  = 2'd0;
  localparam logic [1:0] SEL_MIN  = 2'd1;
  localparam logic [1:0] SEL_HORA = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  localparam logic [7:0] BCD_MAX_59 = 8'h59;
  localparam logic [7:0] BCD_MAX_23 = 8'h23;

  // Both digits must be decimal; once they are, a plain byte compare orders BCD values.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lim);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
  endfunction

endpackage

// File: rtl/temporizador_bcd_dec2.sv
// Two-digit BCD decrement with borrow; a borrow through 00 yields the wrap value.
import temporizador_pkg::*;

module bcd_dec2 (
  input  logic [7:0] value,
  input  logic       borrow_in,
  input  logic [7:0] wrap,
  output logic [7:0] next,
  output logic       borrow_out
);

  always_comb begin
    next       = value;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (value == 8'h00) begin
        next       = wrap;
        borrow_out = 1'b1;
      end else if (value[3:0] == 4'd0) begin
        next = {value[7:4] - 4'd1, 4'd9};
      end else begin
        next = {value[7:4], value[3:0] - 4'd1};
      end
    end
  end

endmodule

// File: rtl/temporizador_bcd.sv
// BCD HH:MM:SS countdown timer with latched alarm and byte-wide count readout.
// Optional TIMER_AUTORELOAD_EN: dismissing the alarm reloads the programmed duration.
import temporizador_pkg::*;

module temporizador_bcd #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] in_hora,
  input  logic [7:0] in_min,
  input  logic [7:0] in_seg,
  input  logic       start,
  input  logic       pause,
  input  logic       btn_desactivar,
  input  logic [1:0] field_sel,
  output logic [7:0] out_count_dato,
  output logic       estado_alarma,
  output logic       running,
  output logic       load_err
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PW       = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  state_t        state;
  logic [PW-1:0] presc;
  logic [7:0]    hora, min, seg;
  logic [7:0]    prog_hora, prog_min, prog_seg;

  logic [7:0] hora_nx, min_nx, seg_nx, sel_byte;
  logic       seg_bo, min_bo, hora_bo;
  logic       tick, load_ok, cnt_zero, zero_next;

  assign tick      = (state == ST_RUN) && (presc == PRE_MAX);
  assign load_ok   = bcd_ok(in_hora, BCD_MAX_23) && bcd_ok(in_min, BCD_MAX_59) &&
                     bcd_ok(in_seg, BCD_MAX_59);
  assign cnt_zero  = ({hora, min, seg} == 24'h0);
  assign zero_next = ({hora_nx, min_nx, seg_nx} == 24'h0);

  bcd_dec2 u_dec_seg (
    .value(seg), .borrow_in(tick), .wrap(BCD_MAX_59),
    .next(seg_nx), .borrow_out(seg_bo)
  );

  bcd_dec2 u_dec_min (
    .value(min), .borrow_in(seg_bo), .wrap(BCD_MAX_59),
    .next(min_nx), .borrow_out(min_bo)
  );

  // Hours never wrap: zero is caught one tick earlier, so hora_bo only guards the update.
  bcd_dec2 u_dec_hora (
    .value(hora), .borrow_in(min_bo), .wrap(8'h00),
    .next(hora_nx), .borrow_out(hora_bo)
  );

  always_comb begin
    sel_byte = 8'h00;
    case (field_sel)
      SEL_SEG:  sel_byte = seg;
      SEL_MIN:  sel_byte = min;
      SEL_HORA: sel_byte = hora;
      SEL_NONE: sel_byte = 8'h00;
      default:  sel_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      presc          <= '0;
      hora           <= 8'h00;
      min            <= 8'h00;
      seg            <= 8'h00;
      prog_hora      <= 8'h00;
      prog_min       <= 8'h00;
      prog_seg       <= 8'h00;
      out_count_dato <= 8'h00;
      estado_alarma  <= 1'b0;
      running        <= 1'b0;
      load_err       <= 1'b0;
    end else begin
      load_err       <= 1'b0;
      out_count_dato <= sel_byte;
      case (state)
        ST_IDLE, ST_PAUSE: begin
          if (load) begin
            if (load_ok) begin
              {hora, min, seg}                <= {in_hora, in_min, in_seg};
              {prog_hora, prog_min, prog_seg} <= {in_hora, in_min, in_seg};
            end else begin
              load_err <= 1'b1;
            end
          end else if (start && !cnt_zero) begin
            state   <= ST_RUN;
            running <= 1'b1;
            // Resuming from PAUSE keeps the partial second already counted.
            if (state == ST_IDLE) presc <= '0;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end else if (tick) begin
            presc <= '0;
            if (!hora_bo) {hora, min, seg} <= {hora_nx, min_nx, seg_nx};
            if (zero_next) begin
              state         <= ST_ALARM;
              running       <= 1'b0;
              estado_alarma <= 1'b1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        ST_ALARM: begin
          if (btn_desactivar) begin
            state         <= ST_IDLE;
            estado_alarma <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
            {hora, min, seg} <= {prog_hora, prog_min, prog_seg};
`else
            {hora, min, seg} <= 24'h0;
`endif
          end
        end
        default: begin
          state         <= ST_IDLE;
          running       <= 1'b0;
          estado_alarma <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_temporizador_bcd.sv
// Self-checking bench for temporizador_bcd: directed steps then random stimulus
// against a seconds-based reference model, with PRESCALE = 4.
module tb_temporizador_bcd;

  logic       clk = 1'b0;
  logic       reset = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, btn_desactivar = 1'b0;
  logic [7:0] in_hora = 8'h00, in_min = 8'h00, in_seg = 8'h00;
  logic [1:0] field_sel = 2'd0;
  logic [7:0] out_count_dato;
  logic       estado_alarma, running, load_err;

  int checks = 0;
  int errors = 0;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;
  localparam int PRESCALE = 4;

  int         m_mode = M_IDLE;
  int         m_secs = 0;
  int         m_prog = 0;
  int         m_presc = 0;
  logic [7:0] m_out = 8'h00;
  logic       m_err = 1'b0;

  temporizador_bcd #(.CLK_HZ(4), .TICK_HZ(1)) dut (
    .clk(clk), .reset(reset), .load(load), .in_hora(in_hora), .in_min(in_min),
    .in_seg(in_seg), .start(start), .pause(pause), .btn_desactivar(btn_desactivar),
    .field_sel(field_sel), .out_count_dato(out_count_dato),
    .estado_alarma(estado_alarma), .running(running), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int bcd_val(input logic [7:0] b, input int lim);
    int hi, lo;
    hi = int'(b[7:4]);
    lo = int'(b[3:0]);
    if (hi > 9 || lo > 9 || (hi * 10 + lo) > lim) return -1;
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] field_of(input int secs, input logic [1:0] sel);
    case (sel)
      2'd0:    return to_bcd(secs % 60);
      2'd1:    return to_bcd((secs / 60) % 60);
      2'd2:    return to_bcd(secs / 3600);
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model advances on the inputs present at the edge it follows.
  task automatic model_edge();
    int h, m, s;
    m_err = 1'b0;
    m_out = field_of(m_secs, field_sel);
    if (reset) begin
      m_mode = M_IDLE; m_secs = 0; m_prog = 0; m_presc = 0; m_out = 8'h00;
    end else begin
      case (m_mode)
        M_IDLE, M_PAUSE: begin
          if (load) begin
            h = bcd_val(in_hora, 23); m = bcd_val(in_min, 59); s = bcd_val(in_seg, 59);
            if (h < 0 || m < 0 || s < 0) m_err = 1'b1;
            else begin
              m_secs = h * 3600 + m * 60 + s;
              m_prog = m_secs;
            end
          end else if (start && m_secs != 0) begin
            if (m_mode == M_IDLE) m_presc = 0;
            m_mode = M_RUN;
          end
        end
        M_RUN: begin
          if (pause) m_mode = M_PAUSE;
          else if (m_presc == PRESCALE - 1) begin
            m_presc = 0;
            m_secs--;
            if (m_secs == 0) m_mode = M_ALARM;
          end else m_presc++;
        end
        default: begin
          if (btn_desactivar) begin
            m_mode = M_IDLE;
`ifdef TIMER_AUTORELOAD_EN
            m_secs = m_prog;
`else
            m_secs = 0;
`endif
          end
        end
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("out_count_dato", out_count_dato, m_out);
    chk("estado_alarma", {7'd0, estado_alarma}, {7'd0, m_mode == M_ALARM});
    chk("running", {7'd0, running}, {7'd0, m_mode == M_RUN});
    chk("load_err", {7'd0, load_err}, {7'd0, m_err});
    reset = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    in_hora = h; in_min = m; in_seg = s; load = 1'b1;
    step();
  endtask

  initial begin
    // Reset state
    reset = 1'b1; step();
    chk("reset_out", out_count_dato, 8'h00);
    chk("reset_run", {7'd0, running}, 8'h00);
    step();

    // 00:00:03 counts down to alarm on the 12th edge after start
    field_sel = 2'd0;
    do_load(8'h00, 8'h00, 8'h03);
    start = 1'b1; step();
    for (int i = 0; i < 11; i++) step();
    chk("pre_alarm", {7'd0, estado_alarma}, 8'h00);
    step();
    chk("alarm_t12", {7'd0, estado_alarma}, 8'h01);
    chk("alarm_run", {7'd0, running}, 8'h00);
    step();
    chk("alarm_cnt", out_count_dato, 8'h00);

    // Dismiss together with start: start must be ignored
    btn_desactivar = 1'b1; start = 1'b1; step();
    btn_desactivar = 1'b0; step();
    chk("dismiss_run", {7'd0, running}, 8'h00);
    chk("dismiss_alarm", {7'd0, estado_alarma}, 8'h00);
`ifdef TIMER_AUTORELOAD_EN
    chk("dismiss_cnt", out_count_dato, 8'h03);
`else
    chk("dismiss_cnt", out_count_dato, 8'h00);
`endif

    // start with a zero count stays in IDLE
    do_load(8'h00, 8'h00, 8'h00);
    start = 1'b1; step(); step();
    chk("start_zero", {7'd0, running}, 8'h00);

    // Borrow chain 01:00:00 -> 00:59:59
    do_load(8'h01, 8'h00, 8'h00);
    start = 1'b1; step();
    for (int i = 0; i < 4; i++) step();
    field_sel = 2'd2; step();
    chk("borrow_hora", out_count_dato, 8'h00);
    field_sel = 2'd1; step();
    chk("borrow_min", out_count_dato, 8'h59);
    field_sel = 2'd0; step();
    chk("borrow_seg", out_count_dato, 8'h59);

    // Reset mid-RUN
    reset = 1'b1; step();
    chk("rst_run_out", out_count_dato, 8'h00);
    chk("rst_run_running", {7'd0, running}, 8'h00);

    // Invalid loads leave the count alone
    do_load(8'h00, 8'h00, 8'h07); step();
    do_load(8'h00, 8'h60, 8'h00);
    chk("err_min60", {7'd0, load_err}, 8'h01);
    do_load(8'h00, 8'h00, 8'h1A);
    chk("err_seg1a", {7'd0, load_err}, 8'h01);
    do_load(8'h24, 8'h00, 8'h00);
    chk("err_hora24", {7'd0, load_err}, 8'h01);
    step();
    chk("err_cnt_kept", out_count_dato, 8'h07);
    do_load(8'h23, 8'h59, 8'h59);
    chk("max_ok", {7'd0, load_err}, 8'h00);

    // Pause at prescaler = 2, hold, resume: decrement lands 2 edges later
    do_load(8'h00, 8'h00, 8'h05);
    start = 1'b1; step();
    step(); step();
    pause = 1'b1; step();
    for (int i = 0; i < 10; i++) step();
    chk("paused_cnt", out_count_dato, 8'h05);
    start = 1'b1; step();
    step(); step();
    chk("resume_pre", out_count_dato, 8'h05);
    step();
    chk("resume_dec", out_count_dato, 8'h04);

    // Random phase against the reference model
    for (int i = 0; i < 3000; i++) begin
      field_sel      = 2'($urandom_range(0, 3));
      btn_desactivar = ($urandom_range(0, 7) == 0);
      pause          = ($urandom_range(0, 29) == 0);
      start          = ($urandom_range(0, 9) == 0);
      reset          = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 39) == 0) begin
        in_hora = to_bcd($urandom_range(0, 1));
        in_min  = to_bcd($urandom_range(0, 2));
        in_seg  = to_bcd($urandom_range(0, 9));
        if ($urandom_range(0, 7) == 0) in_min = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) in_seg = 8'($urandom_range(0, 255));
        load = 1'b1;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
